tpu_tiled_gemm: RTL and testbench

TPU_TILED_GEMM -- requirements
Module: tpu_tiled_gemm

---
 rtl/tpu_tiled_gemm.sv | 184 ++++++++++++++++++
 tb/tb_tpu_tiled_gemm.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_tiled_gemm.sv
// Tiled GEMM engine: C = A * B computed one S x S output tile at a time.
// Per tile: FETCH streams K operand words into an outer-product accumulator
// array, DRAIN absorbs the final read-latency cycle, WRITE emits the valid
// rows of the tile to the C buffer.
//
//   state | meaning
//   IDLE  | waiting for in_valid; zero dimensions answered with done+err
//   FETCH | issue k = 0..K-1 on A_index/B_index
//   DRAIN | last fetched word accumulates
//   WRITE | one C row per cycle, R = min(S, M - mt*S) rows
module tpu_tiled_gemm #(
  parameter int S      = 4,
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        K,
  input  logic [7:0]        M,
  input  logic [7:0]        N,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              A_wr_en,
  output logic              B_wr_en,
  output logic [15:0]       A_index,
  output logic [15:0]       B_index,
  output logic [S*DW-1:0]   A_data_in,
  output logic [S*DW-1:0]   B_data_in,
  input  logic [S*DW-1:0]   A_data_out,
  input  logic [S*DW-1:0]   B_data_out,
  output logic              C_wr_en,
  output logic [15:0]       C_index,
  output logic [S*AW-1:0]   C_data_in,
  input  logic [S*AW-1:0]   C_data_out
);

  localparam int RW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

  state_t          state, state_nxt;
  logic            done_nxt, err_nxt;
  logic [7:0]      k_r, m_r, n_r, kcnt, mt, nt;
  logic [RW-1:0]   rcnt;
  logic            fetch_vld, fetch_first;
  logic            dims_zero, last_k, last_row, last_nt, last_mt;
  logic [15:0]     row_rem;
  logic [AW-1:0]   a_ext [S];
  logic [AW-1:0]   b_ext [S];
  logic [AW-1:0]   prod  [S][S];
  logic [AW-1:0]   acc   [S][S];
  logic            unused_ok;

  assign unused_ok = ^C_data_out;

  assign A_wr_en   = 1'b0;
  assign B_wr_en   = 1'b0;
  assign A_data_in = '0;
  assign B_data_in = '0;
  assign busy      = (state != IDLE);

  assign dims_zero = (K == 8'd0) || (M == 8'd0) || (N == 8'd0);
  assign last_k    = (kcnt == k_r - 8'd1);
  assign row_rem   = 16'(m_r) - 16'(mt) * 16'(S);
  assign last_row  = (16'(rcnt) + 16'd1 >= row_rem) || (rcnt == RW'(S - 1));
  assign last_nt   = (16'(nt) + 16'd1) * 16'(S) >= 16'(n_r);
  assign last_mt   = (16'(mt) + 16'd1) * 16'(S) >= 16'(m_r);

  // state register and registered done/err pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  // next-state decode and completion pulses
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        if (dims_zero) begin
          done_nxt = 1'b1;
          err_nxt  = 1'b1;
        end else begin
          state_nxt = FETCH;
        end
      end
      FETCH: if (last_k) state_nxt = DRAIN;
      DRAIN: state_nxt = WRITE;
      WRITE: if (last_row) begin
        if (last_nt && last_mt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // dimension latches, loop counters and read-valid tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_r <= '0; m_r <= '0; n_r <= '0;
      kcnt <= '0; mt <= '0; nt <= '0; rcnt <= '0;
      fetch_vld   <= 1'b0;
      fetch_first <= 1'b0;
    end else begin
      fetch_vld   <= (state == FETCH);
      fetch_first <= (state == FETCH) && (kcnt == 8'd0);
      case (state)
        IDLE: if (in_valid && !dims_zero) begin
          k_r <= K; m_r <= M; n_r <= N;
          kcnt <= '0; mt <= '0; nt <= '0;
        end
        FETCH: kcnt <= last_k ? 8'd0 : kcnt + 8'd1;
        DRAIN: rcnt <= '0;
        WRITE: begin
          rcnt <= rcnt + RW'(1);
          if (last_row) begin
            if (last_nt) begin
              nt <= '0;
              mt <= mt + 8'd1;
            end else begin
              nt <= nt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // operand extension to accumulator width; products wrap modulo 2^AW
  always_comb begin
    for (int i = 0; i < S; i++) begin
      a_ext[i] = {{(AW-DW){(SIGNED != 0) && A_data_out[i*DW+DW-1]}}, A_data_out[i*DW +: DW]};
      b_ext[i] = {{(AW-DW){(SIGNED != 0) && B_data_out[i*DW+DW-1]}}, B_data_out[i*DW +: DW]};
    end
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        prod[i][j] = a_ext[i] * b_ext[j];
  end

  // outer-product accumulate; the k=0 word overwrites to clear the tile
  always_ff @(posedge clk) begin
    if (fetch_vld)
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++)
          acc[i][j] <= fetch_first ? prod[i][j] : acc[i][j] + prod[i][j];
  end

  // buffer addressing and C row output
  always_comb begin
    A_index   = '0;
    B_index   = '0;
    C_wr_en   = 1'b0;
    C_index   = '0;
    C_data_in = '0;
    if (state == FETCH) begin
      A_index = 16'(mt) * 16'(k_r) + 16'(kcnt);
      B_index = 16'(nt) * 16'(k_r) + 16'(kcnt);
    end
    if (state == WRITE) begin
      C_wr_en = 1'b1;
      C_index = 16'(nt) * 16'(m_r) + 16'(mt) * 16'(S) + 16'(rcnt);
      for (int j = 0; j < S; j++)
        C_data_in[j*AW +: AW] = acc[rcnt][j];
    end
  end

endmodule

// File: tb/tb_tpu_tiled_gemm.sv
// Bench for tpu_tiled_gemm: three instances (unsigned/32, signed/32,
// unsigned/16) share behavioural A/B buffers; a matrix-level reference
// model queues expected C writes and a monitor pops them as they appear.
module tb_tpu_tiled_gemm;
  localparam int S  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    in_valid = '0;
  logic [7:0]    K = '0, M = '0, N = '0;
  logic [2:0]    busy, done, err, a_we, b_we, c_we;
  logic [15:0]   a_idx [3];
  logic [15:0]   b_idx [3];
  logic [15:0]   c_idx [3];
  logic [31:0]   a_din [3];
  logic [31:0]   b_din [3];
  logic [31:0]   a_dout [3];
  logic [31:0]   b_dout [3];
  logic [127:0]  c_din0, c_din1;
  logic [63:0]   c_din2;

  logic [31:0] amem [256];
  logic [31:0] bmem [256];
  int am [16][16];
  int bm [16][16];

  typedef struct { int d; logic [15:0] idx; logic [127:0] data; } exp_t;
  exp_t sbq [$];

  int total = 0;
  int bad   = 0;

  tpu_tiled_gemm #(.S(S), .DW(DW), .AW(32), .SIGNED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .K(K), .M(M), .N(N),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .A_wr_en(a_we[0]), .B_wr_en(b_we[0]),
    .A_index(a_idx[0]), .B_index(b_idx[0]), .A_data_in(a_din[0]), .B_data_in(b_din[0]),
    .A_data_out(a_dout[0]), .B_data_out(b_dout[0]), .C_wr_en(c_we[0]), .C_index(c_idx[0]),
    .C_data_in(c_din0), .C_data_out('0));

  tpu_tiled_gemm #(.S(S), .DW(DW), .AW(32), .SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .K(K), .M(M), .N(N),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .A_wr_en(a_we[1]), .B_wr_en(b_we[1]),
    .A_index(a_idx[1]), .B_index(b_idx[1]), .A_data_in(a_din[1]), .B_data_in(b_din[1]),
    .A_data_out(a_dout[1]), .B_data_out(b_dout[1]), .C_wr_en(c_we[1]), .C_index(c_idx[1]),
    .C_data_in(c_din1), .C_data_out('0));

  tpu_tiled_gemm #(.S(S), .DW(DW), .AW(16), .SIGNED(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .K(K), .M(M), .N(N),
    .busy(busy[2]), .done(done[2]), .err(err[2]), .A_wr_en(a_we[2]), .B_wr_en(b_we[2]),
    .A_index(a_idx[2]), .B_index(b_idx[2]), .A_data_in(a_din[2]), .B_data_in(b_din[2]),
    .A_data_out(a_dout[2]), .B_data_out(b_dout[2]), .C_wr_en(c_we[2]), .C_index(c_idx[2]),
    .C_data_in(c_din2), .C_data_out('0));

  // one-cycle synchronous read buffers
  always @(posedge clk)
    for (int d = 0; d < 3; d++) begin
      a_dout[d] <= amem[a_idx[d][7:0]];
      b_dout[d] <= bmem[b_idx[d][7:0]];
    end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  // monitor: every C write must match the next expected write
  always @(negedge clk)
    for (int d = 0; d < 3; d++)
      if (c_we[d] === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL c_unexpected dut=%0d got_index=%0h want=none", d, c_idx[d]);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("c_dut", 128'(d), 128'(e.d));
          check("c_index", 128'(c_idx[d]), 128'(e.idx));
          check("c_data", (d == 0) ? c_din0 : (d == 1) ? c_din1 : {64'b0, c_din2}, e.data);
        end
      end

  function automatic longint elem(input int x, input int sgn);
    return (sgn != 0 && x > 127) ? longint'(x - 256) : longint'(x);
  endfunction

  // loads the buffers from am/bm, queues the expected C writes, returns busy length
  task automatic model(input int d, input int k, input int m, input int n,
                       input int sgn, input int aw, output int bexp);
    longint c;
    longint mask;
    logic [127:0] row;
    int mtiles, ntiles, rr, col;
    mask   = (aw == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
    mtiles = (m + S - 1) / S;
    ntiles = (n + S - 1) / S;
    for (int w = 0; w < 256; w++) begin
      amem[w] = '0;
      bmem[w] = '0;
    end
    for (int t = 0; t < mtiles; t++)
      for (int kk = 0; kk < k; kk++)
        for (int i = 0; i < S; i++)
          if (t*S + i < m) amem[(t*k + kk) % 256][i*DW +: DW] = 8'(am[t*S+i][kk]);
    for (int t = 0; t < ntiles; t++)
      for (int kk = 0; kk < k; kk++)
        for (int j = 0; j < S; j++)
          if (t*S + j < n) bmem[(t*k + kk) % 256][j*DW +: DW] = 8'(bm[kk][t*S+j]);
    bexp = 0;
    for (int mi = 0; mi < mtiles; mi++)
      for (int ni = 0; ni < ntiles; ni++) begin
        rr = (m - mi*S < S) ? m - mi*S : S;
        bexp += k + 1 + rr;
        for (int r = 0; r < rr; r++) begin
          exp_t e;
          row = '0;
          for (int j = 0; j < S; j++) begin
            col = ni*S + j;
            if (col < n) begin
              c = 0;
              for (int kk = 0; kk < k; kk++)
                c += elem(am[mi*S+r][kk], sgn) * elem(bm[kk][col], sgn);
              row |= 128'(c & mask) << (j*aw);
            end
          end
          e.d = d;
          e.idx = 16'(ni*m + mi*S + r);
          e.data = row;
          sbq.push_back(e);
        end
      end
  endtask

  task automatic run(input int d, input int k, input int m, input int n,
                     input int sgn, input int aw, input int intrude);
    int bexp, cyc, got;
    model(d, k, m, n, sgn, aw, bexp);
    @(negedge clk);
    K = 8'(k); M = 8'(m); N = 8'(n);
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    cyc = 0;
    got = 0;
    for (int t = 0; t < 3000; t++) begin
      if (intrude > 0 && t == intrude) begin
        in_valid[d] = 1'b1;
        K = 8'd1; M = 8'd1; N = 8'd1;
      end else begin
        in_valid[d] = 1'b0;
      end
      if (done[d] === 1'b1) begin
        got = 1;
        break;
      end
      if (busy[d] === 1'b1) cyc++;
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    check("done_seen", 128'(got), 128'd1);
    check("busy_cycles", 128'(cyc), 128'(bexp));
    check("busy_at_done", 128'(busy[d]), 128'd0);
    check("err_at_done", 128'(err[d]), 128'd0);
    @(negedge clk);
    check("done_one_cycle", 128'(done[d]), 128'd0);
    check("writes_all_seen", 128'(sbq.size()), 128'd0);
    sbq.delete();
  endtask

  task automatic fill(input int av, input int bv);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        am[r][c] = (av < 0) ? int'($urandom_range(0, 255)) : av;
        bm[r][c] = (bv < 0) ? int'($urandom_range(0, 255)) : bv;
      end
  endtask

  task automatic zero_dim(input int k, input int m, input int n);
    @(negedge clk);
    K = 8'(k); M = 8'(m); N = 8'(n);
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("zero_done", 128'(done[0]), 128'd1);
    check("zero_err", 128'(err[0]), 128'd1);
    check("zero_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    check("zero_done_clear", 128'(done[0]), 128'd0);
    check("zero_err_clear", 128'(err[0]), 128'd0);
    check("zero_busy_after", 128'(busy[0]), 128'd0);
  endtask

  initial begin
    int bexp, dn;
    for (int w = 0; w < 256; w++) begin
      amem[w] = '0;
      bmem[w] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", 128'(busy[d]), 128'd0);
      check("rst_done", 128'(done[d]), 128'd0);
      check("rst_err", 128'(err[d]), 128'd0);
      check("rst_cwe", 128'(c_we[d]), 128'd0);
      check("rst_aidx", 128'(a_idx[d]), 128'd0);
      check("rst_bidx", 128'(b_idx[d]), 128'd0);
      check("rst_cidx", 128'(c_idx[d]), 128'd0);
    end
    check("rst_cdata", c_din0, 128'd0);
    rst_n = 1'b1;

    // identity A, B[k][j] = 4k+j: C equals B
    fill(0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = (r == c) ? 1 : 0;
        bm[r][c] = 4*r + c;
      end
    run(0, 4, 4, 4, 0, 32, 0);

    // two row tiles with R=4 then R=1, all ones
    fill(1, 1);
    run(0, 2, 5, 3, 0, 32, 0);

    // signed: 0xFF * 0x02 over K=3 -> -6
    fill(255, 2);
    run(1, 3, 4, 4, 1, 32, 0);

    // 16-bit accumulator wrap: 2 * 255 * 255 mod 65536
    fill(255, 255);
    run(2, 2, 4, 4, 0, 16, 0);

    zero_dim(0, 3, 3);
    zero_dim(2, 0, 5);
    zero_dim(4, 4, 0);

    // start request while busy is ignored
    fill(-1, -1);
    run(0, 5, 6, 7, 0, 32, 3);

    // reset during FETCH aborts silently
    fill(0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = (r == c) ? 1 : 0;
        bm[r][c] = 4*r + c;
      end
    model(0, 4, 4, 4, 0, 32, bexp);
    sbq.delete();
    @(negedge clk);
    K = 8'd4; M = 8'd4; N = 8'd4;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 128'(busy[0]), 128'd0);
    check("abort_aidx", 128'(a_idx[0]), 128'd0);
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0] === 1'b1) dn++;
    end
    check("abort_no_done", 128'(dn), 128'd0);
    check("abort_idle", 128'(busy[0]), 128'd0);
    run(0, 4, 4, 4, 0, 32, 0);

    // randomized shapes and data
    for (int it = 0; it < 8; it++) begin
      int d;
      d = int'($urandom_range(0, 2));
      fill(-1, -1);
      run(d, int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
          (d == 1) ? 1 : 0, (d == 2) ? 16 : 32, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
